// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int unsigned XLEN_DEF = 64;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mdu_state_t;

  // Op codes 5-7 are reserved and complete immediately with a zero result.
  function automatic logic op_reserved(input logic [2:0] op);
    return op > 3'd4;
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response handshake bundle between the execute stage and the MDU.
interface mdu_seq_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mdu_seq_step.sv
// One radix-2 iteration of the shared shift-add multiply / restoring divide engine.
module mdu_seq_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic            is_mul,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] opnd_next,
  output logic [XLEN-1:0] dvsr_next,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Multiply: acc += multiplicand when multiplier LSB set. Divide: shift rem:quot, trial subtract.
  always_comb begin
    acc_next  = acc;
    opnd_next = opnd;
    dvsr_next = dvsr;
    q_bit     = 1'b0;
    shifted   = {acc, opnd[XLEN-1]};
    // Only taken when shifted >= dvsr, so the true difference is < dvsr and fits XLEN bits.
    diff      = shifted[XLEN-1:0] - dvsr;
    if (is_mul) begin
      acc_next  = acc + (opnd[0] ? dvsr : '0);
      opnd_next = opnd >> 1;
      dvsr_next = dvsr << 1;
    end else begin
      q_bit     = (shifted >= {1'b0, dvsr});
      acc_next  = q_bit ? diff : shifted[XLEN-1:0];
      opnd_next = {opnd[XLEN-2:0], q_bit};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequencer for the iterative M-extension multiply/divide engine.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  mdu_seq_if.slave    bus,
  output logic        busy
);

  mdu_state_t      state, state_nx;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_q, opnd_q, dvsr_q, result_q;
  logic            neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept, last;
  logic            div_fam, is_signed, is_rem, b_zero, ovf, special, a_neg, b_neg;
  logic [XLEN-1:0] special_res, a_mag, b_mag, fix_res;
  logic [XLEN-1:0] acc_nx, opnd_nx, dvsr_nx;
  logic            q_bit;

  assign accept         = (state == S_IDLE) && bus.req_valid && !flush;
  assign last           = (cnt_q == CNT_W'(XLEN - 1));
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_data  = result_q;
  assign busy           = (state != S_IDLE);

  mdu_seq_step #(.XLEN(XLEN)) u_step (
    .is_mul    (op_q == OP_MUL),
    .acc       (acc_q),
    .opnd      (opnd_q),
    .dvsr      (dvsr_q),
    .acc_next  (acc_nx),
    .opnd_next (opnd_nx),
    .dvsr_next (dvsr_nx),
    .q_bit     (q_bit)
  );

  // Decode the incoming request: operand magnitudes, sign flags and immediate-result cases.
  always_comb begin
    div_fam     = bus.req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_signed   = (bus.req_op == OP_DIV) || (bus.req_op == OP_REM);
    is_rem      = (bus.req_op == OP_REM) || (bus.req_op == OP_REMU);
    b_zero      = (bus.req_b == '0);
    ovf         = is_signed && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
    special     = op_reserved(bus.req_op) || (div_fam && (b_zero || ovf));
    special_res = '0;
    if (div_fam && b_zero)   special_res = is_rem ? bus.req_a : '1;
    else if (div_fam && ovf) special_res = is_rem ? '0 : bus.req_a;
    a_neg = is_signed && bus.req_a[XLEN-1];
    b_neg = is_signed && bus.req_b[XLEN-1];
    a_mag = a_neg ? -bus.req_a : bus.req_a;
    b_mag = b_neg ? -bus.req_b : bus.req_b;
  end

  // Sign fix-up applied to the final iteration's outputs.
  always_comb begin
    case (op_q)
      OP_MUL:           fix_res = acc_nx;
      OP_DIV, OP_DIVU:  fix_res = neg_quo_q ? -opnd_nx : opnd_nx;
      default:          fix_res = neg_rem_q ? -acc_nx : acc_nx;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.req_valid) state_nx = special ? S_DONE : S_BUSY;
        S_BUSY:  if (last) state_nx = S_DONE;
        S_DONE:  if (bus.resp_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture on accept, one engine step per BUSY cycle, result on completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q      <= bus.req_op;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      // Multiply keeps raw operands (low bits are sign-agnostic); divide works on magnitudes.
      opnd_q    <= (bus.req_op == OP_MUL) ? bus.req_b : a_mag;
      dvsr_q    <= (bus.req_op == OP_MUL) ? bus.req_a : b_mag;
      if (special) result_q <= special_res;
    end else if (state == S_BUSY) begin
      acc_q  <= acc_nx;
      opnd_q <= opnd_nx;
      dvsr_q <= dvsr_nx;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) result_q <= fix_res;
    end
  end

endmodule
